// File: rtl/rtc_escritor_bus.sv
// rtc_escritor_bus: snapshots six BCD edit registers and writes them plus a transfer command to the RTC bus.
module rtc_escritor_bus #(
  parameter int T_FASE = 10,
  parameter logic [7:0] ADDR_BASE = 8'h21,
  parameter logic [7:0] CMD_TRANSFER = 8'hF2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Iniciar,
  input  logic [7:0] DATA_seg,
  input  logic [7:0] DATA_min,
  input  logic [7:0] DATA_hora,
  input  logic [7:0] DATA_dia,
  input  logic [7:0] DATA_mes,
  input  logic [7:0] DATA_anio,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       AD_n,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       Ocupado,
  output logic       Listo
);
  localparam int CW = T_FASE > 1 ? $clog2(T_FASE) : 1;
  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, A_GAP, D_SETUP, D_STROBE, D_HOLD, D_GAP, DONE
  } state_t;
  state_t state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0] snap [6];
  logic [7:0] addr, data, out_nxt;
  logic last, drv_a, drv_d;
  assign last = cnt == CW'(T_FASE - 1);
  assign RD_n = 1'b1;
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    cnt_nxt = cnt;
    if (state == IDLE) begin
      state_nxt = Iniciar ? A_SETUP : IDLE;
      idx_nxt = 3'd0;
    end else if (state == DONE) begin
      state_nxt = IDLE;
    end else if (!last) begin
      cnt_nxt = cnt + 1'b1;
    end else begin
      cnt_nxt = '0;
      if (state == D_GAP) begin
        state_nxt = idx == 3'd6 ? DONE : A_SETUP;
        idx_nxt = idx == 3'd6 ? idx : idx + 3'd1;
      end else begin
        state_nxt = state_t'(4'(state + 4'd1));
      end
    end
  end
  // Outputs are decoded from the next state so the pins are registered yet aligned with the state.
  always_comb begin
    addr = idx_nxt == 3'd6 ? CMD_TRANSFER : ADDR_BASE + {5'd0, idx_nxt};
    data = idx_nxt < 3'd6 ? snap[idx_nxt] : 8'h00;
    drv_a = state_nxt == A_SETUP || state_nxt == A_STROBE || state_nxt == A_HOLD;
    drv_d = state_nxt == D_SETUP || state_nxt == D_STROBE || state_nxt == D_HOLD;
    out_nxt = drv_a ? addr : drv_d ? data : 8'h00;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      idx <= 3'd0;
      cnt <= '0;
      CS_n <= 1'b1;
      WR_n <= 1'b1;
      AD_n <= 1'b0;
      AD_out <= 8'h00;
      AD_oe <= 1'b0;
      Ocupado <= 1'b0;
      Listo <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      CS_n <= !(drv_a || drv_d);
      WR_n <= !(state_nxt == A_STROBE || state_nxt == D_STROBE);
      AD_n <= drv_d;
      AD_out <= out_nxt;
      AD_oe <= drv_a || drv_d;
      Ocupado <= state_nxt != IDLE && state_nxt != DONE;
      Listo <= state_nxt == DONE;
    end
  end
  always_ff @(posedge CLK) begin
    if (state == IDLE && Iniciar) begin
      snap[0] <= DATA_seg;
      snap[1] <= DATA_min;
      snap[2] <= DATA_hora;
      snap[3] <= DATA_dia;
      snap[4] <= DATA_mes;
      snap[5] <= DATA_anio;
    end
  end
endmodule

// File: doc/rtc_escritor_bus.md
# rtc_escritor_bus

Write-side bus sequencer toward the external RTC's multiplexed address/data port. It takes a snapshot of the six BCD time/date edit registers (seconds, minutes, hours, day, month, year) when triggered. It then drives seven write transactions onto the RTC bus: the six register writes, then the transfer command that commits them. It sits between the edit register bank and the RTC pins, sharing the bus with the read sequencer, which fills the registers through their update inputs.

## Interface
- T_FASE, 10: clock cycles per bus phase, ≥1 (10 = 100 ns at 100 MHz).
- ADDR_BASE, 8'h21: RTC address of seconds; minutes..year follow at +1..+5.
- CMD_TRANSFER, 8'hF2: command address written last; its data byte is 8'h00.
- CLK  in  1  general circuit clock, single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- Iniciar  in  1  start request, level-sampled in IDLE only.
- DATA_seg, DATA_min, DATA_hora, DATA_dia, DATA_mes, DATA_anio  in  8 each  BCD values from the edit registers.
- CS_n  out  1  RTC chip select, active low.
- WR_n  out  1  RTC write strobe, active low.
- RD_n  out  1  RTC read strobe; always 1 in this block.
- AD_n  out  1  bus phase select: 0 = address, 1 = data.
- AD_out  out  8  value driven on the bus.
- AD_oe  out  1  bus drive enable to the top-level tristate.
- Ocupado  out  1  high from the first bus phase through the last.
- Listo  out  1  one-cycle completion pulse.

## Operation
- Reset values:
  - CS_n=1, WR_n=1, RD_n=1, AD_n=0.
  - AD_out=8'h00, AD_oe=0.
  - Ocupado=0, Listo=0.
  - State IDLE, transaction index 0, phase counter 0.
- IDLE:
  - If Iniciar=1, latch all six DATA inputs into internal snapshot registers on that edge.
  - Go to A_SETUP with index 0.
  - Later input changes do not affect the current sequence.
- Transaction index k=0..5:
  - Address = ADDR_BASE+k; data = snapshot k (seg, min, hora, dia, mes, anio).
- Transaction index k=6:
  - Address = CMD_TRANSFER; data = 8'h00.
- States per transaction, each lasting exactly T_FASE cycles:
  - A_SETUP: CS_n=0, AD_n=0, AD_oe=1, AD_out=address, WR_n=1.
  - A_STROBE: as A_SETUP, but WR_n=0.
  - A_HOLD: as A_SETUP (WR_n=1); address stays stable.
  - A_GAP: CS_n=1, AD_oe=0.
  - D_SETUP: CS_n=0, AD_n=1, AD_oe=1, AD_out=data, WR_n=1.
  - D_STROBE: as D_SETUP, but WR_n=0.
  - D_HOLD: as D_SETUP.
  - D_GAP: CS_n=1, AD_oe=0, AD_n=0.
- After D_GAP:
  - If index<6: increment index, go to A_SETUP.
  - If index=6: go to DONE.
- DONE (one cycle): Listo=1, Ocupado=0, all bus outputs at their reset values; then IDLE.
- Ocupado=1 in every state except IDLE and DONE.
- Iniciar is ignored outside IDLE; a start request held through DONE is honoured in the following IDLE cycle.
- Phase counter: width sized for T_FASE-1. It counts 0..T_FASE-1, resets to 0 on each state change, and does not wrap inside a phase.
- Data values pass through unmodified; no BCD validation.
- Outputs are registered; no combinational path from inputs to pins.
- RESET mid-sequence: all outputs return to reset values immediately (asynchronous). The bus is released and no Listo is generated. A new sequence starts only on a fresh Iniciar after RESET is released.

## Timing
- Edge E0 samples Iniciar=1. A_SETUP outputs become visible after E0.
- Each transaction = 8·T_FASE cycles; the full sequence = 56·T_FASE cycles.
- Listo is high during cycle 56·T_FASE+1 counted from E0 (cycle 561 for T_FASE=10), for one cycle only.
- WR_n low pulse width = T_FASE cycles, in both address and data phases.
- AD_out and AD_n are stable T_FASE cycles before WR_n falls and T_FASE cycles after it rises.
- CS_n is high for T_FASE cycles between the address and data phases, and between transactions.
- Minimum spacing between sequences: 56·T_FASE+2 cycles from one accepted Iniciar to the next.

## Test plan
- Reset then idle, T_FASE=2: all outputs at reset values. Hold Iniciar=0 for 100 cycles -> no CS_n activity.
- T_FASE=2, snapshot values seg=8'h59, min=8'h30, hora=8'h23, dia=8'h31, mes=8'h12, anio=8'h99, single-cycle Iniciar:
  - Bus monitor captures address/data pairs (21,59)(22,30)(23,23)(24,31)(25,12)(26,99)(F2,00).
  - Listo is asserted exactly 113 cycles after the sampling edge.
- Change DATA_mes from 8'h12 to 8'h01 during transaction 2 -> the month write still carries 8'h12.
- Hold Iniciar high continuously -> back-to-back sequences:
  - exactly one Listo per sequence;
  - exactly one IDLE cycle between DONE and the next A_SETUP.
- Assert RESET during D_STROBE of transaction 3:
  - CS_n=1, WR_n=1, AD_oe=0 within the same cycle;
  - no Listo;
  - the next Iniciar restarts at address 8'h21.
- T_FASE=1 -> every phase lasts one cycle; seven pairs observed; Listo 57 cycles after start.
